// File: rtl/tt_sweep_capture.sv
// +--------------------------------------------------------------------------+
// | tt_sweep_capture: walks all 128 input codes of a 7-input function block, |
// | captures its truth table and compares it against EXPECTED.               |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module tt_sweep_capture #(
  parameter logic [127:0] EXPECTED   = 128'h0,
  parameter int           SAMPLE_LAT = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         abort,
  input  logic         f_in,
  output logic [6:0]   x_out,
  output logic         busy,
  output logic         done,
  output logic [127:0] tt,
  output logic         match,
  output logic [7:0]   mism_cnt,
  output logic [6:0]   first_mism,
  output logic         first_mism_vld
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t         state_q, state_d;
  logic [6:0]     x_out_q, x_out_d;
  logic [127:0]   tt_q, tt_d;
  logic [7:0]     mism_cnt_q, mism_cnt_d;
  logic [6:0]     first_mism_q, first_mism_d;
  logic           first_mism_vld_q, first_mism_vld_d;
  logic           match_q, match_d;

  logic           drive_vld;
  logic           in_sweep;
  logic           abort_now;
  logic           samp_vld;
  logic [6:0]     samp_idx;
  logic           take;
  logic           last_take;

  assign drive_vld = (state_q == ST_DRIVE);
  assign in_sweep  = (state_q == ST_DRIVE) || (state_q == ST_DRAIN);
  assign abort_now = abort && in_sweep;

  // Index/valid travel alongside the stimulus so each sample knows its index.
  if (SAMPLE_LAT == 1) begin : g_lat_direct
    assign samp_vld = drive_vld;
    assign samp_idx = x_out_q;
  end else begin : g_lat_pipe
    logic [SAMPLE_LAT-2:0] dly_vld_q, dly_vld_d;
    logic [6:0]            dly_idx_q [SAMPLE_LAT-1];
    logic [6:0]            dly_idx_d [SAMPLE_LAT-1];

    always_comb begin
      dly_vld_d    = dly_vld_q;
      dly_idx_d    = dly_idx_q;
      dly_vld_d[0] = drive_vld;
      dly_idx_d[0] = x_out_q;
      for (int k = 1; k < SAMPLE_LAT - 1; k++) begin
        dly_vld_d[k] = dly_vld_q[k-1];
        dly_idx_d[k] = dly_idx_q[k-1];
      end
    end

    always_ff @(posedge clk) begin
      if (rst || abort_now) begin
        dly_vld_q <= '0;
        for (int k = 0; k < SAMPLE_LAT - 1; k++) begin
          dly_idx_q[k] <= 7'd0;
        end
      end else begin
        dly_vld_q <= dly_vld_d;
        dly_idx_q <= dly_idx_d;
      end
    end

    assign samp_vld = dly_vld_q[SAMPLE_LAT-2];
    assign samp_idx = dly_idx_q[SAMPLE_LAT-2];
  end

  assign take      = samp_vld && !abort_now;
  assign last_take = take && (samp_idx == 7'd127);

  always_comb begin
    state_d          = state_q;
    x_out_d          = x_out_q;
    tt_d             = tt_q;
    mism_cnt_d       = mism_cnt_q;
    first_mism_d     = first_mism_q;
    first_mism_vld_d = first_mism_vld_q;
    match_d          = match_q;

    if (take) begin
      tt_d[samp_idx] = f_in;
      if (f_in != EXPECTED[samp_idx]) begin
        mism_cnt_d = mism_cnt_q + 8'd1;
        if (!first_mism_vld_q) begin
          first_mism_d     = samp_idx;
          first_mism_vld_d = 1'b1;
        end
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d          = ST_DRIVE;
          x_out_d          = 7'd0;
          tt_d             = '0;
          mism_cnt_d       = 8'd0;
          match_d          = 1'b0;
          first_mism_vld_d = 1'b0;
        end
      end
      ST_DRIVE: begin
        if (abort) begin
          state_d = ST_IDLE;
          x_out_d = 7'd0;
        end else if (last_take) begin
          // Only reachable here when the block has no extra latency.
          state_d = ST_DONE;
          x_out_d = 7'd0;
          match_d = (mism_cnt_d == 8'd0);
        end else if (x_out_q == 7'd127) begin
          state_d = ST_DRAIN;
        end else begin
          x_out_d = x_out_q + 7'd1;
        end
      end
      ST_DRAIN: begin
        if (abort) begin
          state_d = ST_IDLE;
          x_out_d = 7'd0;
        end else if (last_take) begin
          state_d = ST_DONE;
          x_out_d = 7'd0;
          match_d = (mism_cnt_d == 8'd0);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= ST_IDLE;
      x_out_q          <= 7'd0;
      tt_q             <= '0;
      mism_cnt_q       <= 8'd0;
      first_mism_q     <= 7'd0;
      first_mism_vld_q <= 1'b0;
      match_q          <= 1'b0;
    end else begin
      state_q          <= state_d;
      x_out_q          <= x_out_d;
      tt_q             <= tt_d;
      mism_cnt_q       <= mism_cnt_d;
      first_mism_q     <= first_mism_d;
      first_mism_vld_q <= first_mism_vld_d;
      match_q          <= match_d;
    end
  end

  assign x_out          = x_out_q;
  assign busy           = in_sweep;
  assign done           = (state_q == ST_DONE);
  assign tt             = tt_q;
  assign match          = match_q;
  assign mism_cnt       = mism_cnt_q;
  assign first_mism     = first_mism_q;
  assign first_mism_vld = first_mism_vld_q;

endmodule

`default_nettype wire

// File: tb/tb_tt_sweep_capture.sv
// +--------------------------------------------------------------------------+
// | tb_tt_sweep_capture: scoreboard bench for tt_sweep_capture (latency 1/2).|
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module tb_tt_sweep_capture;

  localparam logic [127:0] EXP = 128'heeeaeaeaeeaae888eee8aa88a8a8a888;

  typedef struct {
    logic [127:0] tt;
    logic         match;
    logic [7:0]   mism;
    logic [6:0]   first;
    logic         first_vld;
    int           edges;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_a, start_a, abort_a, f_in_a;
  logic [6:0]   x_out_a;
  logic         busy_a, done_a, match_a, fmv_a;
  logic [127:0] tt_a;
  logic [7:0]   mc_a;
  logic [6:0]   fm_a;

  logic         rst_b, start_b, abort_b, f_in_b;
  logic [6:0]   x_out_b;
  logic         busy_b, done_b, match_b, fmv_b;
  logic [127:0] tt_b;
  logic [7:0]   mc_b;
  logic [6:0]   fm_b;

  tt_sweep_capture #(.EXPECTED(EXP), .SAMPLE_LAT(1)) dut_a (
    .clk(clk), .rst(rst_a), .start(start_a), .abort(abort_a), .f_in(f_in_a),
    .x_out(x_out_a), .busy(busy_a), .done(done_a), .tt(tt_a), .match(match_a),
    .mism_cnt(mc_a), .first_mism(fm_a), .first_mism_vld(fmv_a)
  );

  tt_sweep_capture #(.EXPECTED(EXP), .SAMPLE_LAT(2)) dut_b (
    .clk(clk), .rst(rst_b), .start(start_b), .abort(abort_b), .f_in(f_in_b),
    .x_out(x_out_b), .busy(busy_b), .done(done_b), .tt(tt_b), .match(match_b),
    .mism_cnt(mc_b), .first_mism(fm_b), .first_mism_vld(fmv_b)
  );

  // Function-block models: 0 = combinational, 1 = stuck 0, 2 = inverted, 3 = registered.
  int   mode_a = 0;
  logic f_reg_a, f_reg_b;
  always @(posedge clk) begin
    f_reg_a <= EXP[x_out_a];
    f_reg_b <= EXP[x_out_b];
  end
  always_comb begin
    case (mode_a)
      0:       f_in_a = EXP[x_out_a];
      1:       f_in_a = 1'b0;
      2:       f_in_a = ~EXP[x_out_a];
      default: f_in_a = f_reg_a;
    endcase
  end
  assign f_in_b = f_reg_b;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int   total = 0;
  int   bad   = 0;
  exp_t sb_a[$];
  exp_t sb_b[$];
  int   start_cyc_a = 0, start_cyc_b = 0;
  int   done_seen_a = 0, done_seen_b = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, want);
    end
  endtask

  task automatic check_res(input string tag, input exp_t e, input logic [127:0] t,
                           input logic m, input logic [7:0] mc, input logic [6:0] fm,
                           input logic fv, input logic b, input int edges);
    chk({tag, "_tt"}, t, e.tt);
    chk({tag, "_match"}, 128'(m), 128'(e.match));
    chk({tag, "_mism_cnt"}, 128'(mc), 128'(e.mism));
    chk({tag, "_first_vld"}, 128'(fv), 128'(e.first_vld));
    if (e.first_vld) chk({tag, "_first_mism"}, 128'(fm), 128'(e.first));
    chk({tag, "_done_edges"}, 128'(edges), 128'(e.edges));
    chk({tag, "_busy_at_done"}, 128'(b), 128'd0);
  endtask

  task automatic monitor_loop();
    exp_t e;
    forever begin
      @(negedge clk);
      if (done_a) begin
        if (sb_a.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_done_a: got done=1 expected none at cycle %0d", cyc);
        end else begin
          e = sb_a.pop_front();
          check_res("a", e, tt_a, match_a, mc_a, fm_a, fmv_a, busy_a, cyc - start_cyc_a + 1);
        end
        done_seen_a++;
      end
      if (done_b) begin
        if (sb_b.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_done_b: got done=1 expected none at cycle %0d", cyc);
        end else begin
          e = sb_b.pop_front();
          check_res("b", e, tt_b, match_b, mc_b, fm_b, fmv_b, busy_b, cyc - start_cyc_b + 1);
        end
        done_seen_b++;
      end
    end
  endtask

  // Returns at the negedge right after the accepting edge; cyc then counts that edge.
  task automatic start_pulse(input bit which);
    @(negedge clk);
    if (which) start_b = 1'b1; else start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    start_b = 1'b0;
    if (which) start_cyc_b = cyc; else start_cyc_a = cyc;
  endtask

  task automatic wait_done(input bit which, input int seen);
    for (int k = 0; k < 400; k++) begin
      if ((which ? done_seen_b : done_seen_a) != seen) return;
      @(negedge clk);
    end
    total++; bad++;
    $display("FAIL done_timeout_%0d: got no done expected one within 400 cycles", which);
  endtask

  task automatic wait_x_a(input logic [6:0] v);
    for (int k = 0; k < 300; k++) begin
      if (x_out_a == v) return;
      @(negedge clk);
    end
    total++; bad++;
    $display("FAIL wait_x: got x_out=%0d expected %0d", x_out_a, v);
  endtask

  task automatic sweep(input bit which, input exp_t e, input bit walk, input bit mid_start);
    int seen;
    int errs;
    seen = which ? done_seen_b : done_seen_a;
    if (which) sb_b.push_back(e); else sb_a.push_back(e);
    start_pulse(which);
    if (walk) begin
      errs = 0;
      for (int i = 0; i < 128; i++) begin
        if (x_out_a != 7'(i) || busy_a !== 1'b1) errs++;
        if (i < 127) @(negedge clk);
      end
      chk("x_walk_errors", 128'(errs), 128'd0);
    end
    if (mid_start) begin
      repeat (40) @(negedge clk);
      start_a = 1'b1;
      @(negedge clk);
      start_a = 1'b0;
    end
    wait_done(which, seen);
  endtask

  function automatic int popcnt(input logic [127:0] v);
    int n = 0;
    for (int i = 0; i < 128; i++) n += int'(v[i]);
    return n;
  endfunction

  function automatic int lowest(input logic [127:0] v);
    for (int i = 0; i < 128; i++) if (v[i]) return i;
    return 0;
  endfunction

  exp_t         e_ok, e_ok2, e_zero, e_inv, e_reg;
  logic [127:0] tt_shift;

  initial begin
    fork
      monitor_loop();
    join_none

    rst_a = 1'b1; rst_b = 1'b1;
    start_a = 1'b0; start_b = 1'b0;
    abort_a = 1'b0; abort_b = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_tt_a", tt_a, 128'd0);
    chk("reset_ctl_a", 128'({x_out_a, busy_a, done_a, match_a, mc_a, fm_a, fmv_a}), 128'd0);
    chk("reset_ctl_b", 128'({x_out_b, busy_b, done_b, match_b, mc_b, fm_b, fmv_b}), 128'd0);
    rst_a = 1'b0; rst_b = 1'b0;
    repeat (2) @(negedge clk);

    e_ok   = '{tt: EXP, match: 1'b1, mism: 8'd0, first: 7'd0, first_vld: 1'b0, edges: 129};
    e_ok2  = '{tt: EXP, match: 1'b1, mism: 8'd0, first: 7'd0, first_vld: 1'b0, edges: 130};
    e_zero = '{tt: 128'd0, match: 1'b0, mism: 8'd64, first: 7'd3, first_vld: 1'b1, edges: 129};
    e_inv  = '{tt: ~EXP, match: 1'b0, mism: 8'd128, first: 7'd0, first_vld: 1'b1, edges: 129};
    // Registered block seen with latency 1: index i captures f(i-1), index 0 sees f(0).
    tt_shift = {EXP[126:0], EXP[0]};
    e_reg  = '{tt: tt_shift, match: 1'b0, mism: 8'(popcnt(tt_shift ^ EXP)),
               first: 7'(lowest(tt_shift ^ EXP)), first_vld: 1'b1, edges: 129};

    mode_a = 0; sweep(1'b0, e_ok, 1'b1, 1'b0);
    mode_a = 1; sweep(1'b0, e_zero, 1'b0, 1'b0);
    mode_a = 2; sweep(1'b0, e_inv, 1'b0, 1'b0);
    repeat (5) @(negedge clk);
    chk("hold_tt_a", tt_a, ~EXP);
    chk("hold_cnt_a", 128'(mc_a), 128'd128);

    sweep(1'b1, e_ok2, 1'b0, 1'b0);
    mode_a = 3; sweep(1'b0, e_reg, 1'b0, 1'b0);
    chk("reg_lat1_has_mism", 128'(mc_a != 8'd0), 128'd1);

    // Abort mid-drive.
    mode_a = 0;
    start_pulse(1'b0);
    wait_x_a(7'd50);
    abort_a = 1'b1;
    @(negedge clk);
    abort_a = 1'b0;
    chk("abort_busy", 128'(busy_a), 128'd0);
    chk("abort_x_out", 128'(x_out_a), 128'd0);
    chk("abort_match", 128'(match_a), 128'd0);
    repeat (200) @(negedge clk);
    sweep(1'b0, e_ok, 1'b0, 1'b0);

    // Start while busy must not restart or add a done.
    sweep(1'b0, e_ok, 1'b0, 1'b1);
    repeat (200) @(negedge clk);

    // Reset mid-sweep.
    start_pulse(1'b0);
    wait_x_a(7'd90);
    rst_a = 1'b1;
    @(negedge clk);
    rst_a = 1'b0;
    chk("midrst_tt_a", tt_a, 128'd0);
    chk("midrst_ctl_a", 128'({x_out_a, busy_a, done_a, match_a, mc_a, fm_a, fmv_a}), 128'd0);
    repeat (200) @(negedge clk);

    chk("sb_a_left", 128'(sb_a.size()), 128'd0);
    chk("sb_b_left", 128'(sb_b.size()), 128'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish expected finish before 1ms");
    $fatal(1);
  end

endmodule

`default_nettype wire
